alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Initiator side of the 8-bit combinational ALU (a, b, sel -> out, carryout).
//  Buffers opcode/operand commands from a valid/ready source, drives them one at a time
//  onto the ALU operand/select lines, waits a settle time, captures result and carry,
//  and returns a tagged response on a valid/ready sink. Rejects divide-by-zero and
//  undefined opcodes without presenting them to the ALU.
// PARAMETERS
//  DEPTH        4   command FIFO entries; power of 2, >= 2
//  WAIT_CYCLES  1   cycles operands are held on the ALU before capture; >= 1
// PORTS
//  clk        in   1  clock, all logic on rising edge
//  rst_n      in   1  synchronous reset, active low
//  cmd_valid  in   1  command offered
//  cmd_ready  out  1  FIFO can accept (registered, = !full)
//  cmd_op     in   4  ALU opcode (0 add,1 sub,2 mul,3 div,4 shl,5 shr,6 and,7 or)
//  cmd_a      in   8  operand a
//  cmd_b      in   8  operand b
//  cmd_tag    in   4  user tag, echoed on response
//  alu_a      out  8  to ALU a (registered)
//  alu_b      out  8  to ALU b (registered)
//  alu_sel    out  4  to ALU sel (registered)
//  alu_out    in   8  from ALU out
//  alu_carry  in   1  from ALU carryout
//  rsp_valid  out  1  response available
//  rsp_ready  in   1  sink accepts response
//  rsp_data   out  8  captured result
//  rsp_carry  out  1  captured carry; meaningful for op 0 only, else 0
//  rsp_tag    out  4  tag of the command
//  rsp_err    out  1  1 = div-by-zero (op 3, b==0) or op >= 8
//  busy       out  1  1 when state != IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (rst_n low at edge): FIFO emptied (pointers/count 0), state IDLE, all outputs 0
//   except cmd_ready=1. In-flight command and pending response discarded; no partial rsp.
//  FIFO: push on cmd_valid&&cmd_ready; pop only from IDLE when non-empty. Pointers wrap
//   mod DEPTH. Push+pop same edge: count unchanged. Full: cmd_ready=0, cmd_valid ignored.
//   Empty: no pop. cmd_ready depends on registered count only (no same-cycle pop bypass).
//  FSM states IDLE, DRIVE, RESP:
//   IDLE  -> pop head. Valid op: load alu_a/b/sel, wait_cnt=WAIT_CYCLES-1, -> DRIVE.
//            Error op: alu_* unchanged, rsp_data=8'h00, rsp_carry=0, rsp_err=1, -> RESP.
//   DRIVE -> wait_cnt>0: decrement. wait_cnt==0: rsp_data<=alu_out,
//            rsp_carry<=(sel==0)?alu_carry:0, rsp_err<=0, rsp_tag<=tag, -> RESP.
//   RESP  -> rsp_valid=1; rsp_* stable while rsp_valid&&!rsp_ready.
//            On rsp_ready: rsp_valid=0 next cycle, -> IDLE.
//  Latency (empty FIFO, WAIT_CYCLES=1, rsp_ready=1): cmd accepted edge 0, popped edge 1,
//   captured edge 2, rsp_valid high cycle after edge 2, i.e. 2 edges; error cmd: 1 edge.
//   General valid op: 1+WAIT_CYCLES edges. Throughput: one cmd per WAIT_CYCLES+2 cycles.
//  alu_a/b/sel hold last driven values between commands (ALU stays quiet).
//  Responses leave strictly in command order; no reordering, no drop except by reset.
//  Arithmetic done by the ALU only; rsp_data is the 8-bit truncated ALU result.
// STRUCTURE
//  Package alu_pkg: opcode localparams OP_ADD..OP_OR, OP_LAST=4'd7, FSM state encoding,
//   command struct width (4 op + 8 a + 8 b + 4 tag = 24 bits).
//  Sub-module alu_cmd_fifo (DEPTH x 24, push/pop/full/empty/count); FSM, wait counter
//   and response registers in this module. Bench instantiates the existing ALU as DUT peer.
// TESTING
//  1 Single add: op0 a=8'hF0 b=8'h20 tag=3 -> rsp_data=8'h10, rsp_carry=1, tag=3, 2 edges.
//  2 Div-by-zero: op3 a=8'h09 b=0 -> rsp_err=1, rsp_data=0, alu_* unchanged, 1 edge.
//  3 Backpressure: rsp_ready=0, push 5 cmds (DEPTH=4) -> cmd_ready low after 4 queued
//    + 1 in flight; rsp held stable; releasing rsp_ready drains in order tags 0..4.
//  4 Mixed ops: mul 8'h10*8'h11 -> 8'h10; sub 3-5 -> 8'hFE carry 0; shl 8'h81 -> 8'h02;
//    op 4'hA -> rsp_err=1.
//  5 Reset mid-DRIVE with 2 queued -> next cycle rsp_valid=0, busy=0, cmd_ready=1, no
//    stale responses after release.
//  6 Simultaneous push/pop at count=2 -> count stays 2; WAIT_CYCLES=3 gives 4-edge latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM and command definitions for the ALU command sequencer.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_LAST = 4'd7;

  localparam int CMD_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] tag;
  } cmd_t;

  // Commands that must never reach the ALU.
  function automatic logic is_err_cmd(input cmd_t c);
    return (c.op > OP_LAST) || ((c.op == OP_DIV) && (c.b == 8'h00));
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command (valid/ready source) and response (valid/ready sink) bundle of the sequencer.
interface alu_cmd_sequencer_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_tag;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic [3:0] rsp_tag;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_tag, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_tag, rsp_err
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO, DEPTH entries of cmd_t, head visible combinationally for the IDLE pop.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  cmd_t                     din,
  input  logic                     pop,
  output cmd_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  cmd_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds queued commands one at a time to an external combinational ALU and returns
// tagged, in-order responses; bad opcodes and divide-by-zero are answered locally.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_cmd_sequencer_if.slave   bus,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [3:0]           alu_sel,
  input  logic [7:0]           alu_out,
  input  logic                 alu_carry,
  output logic                 busy
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]     alu_a_q, alu_a_d;
  logic [7:0]     alu_b_q, alu_b_d;
  logic [3:0]     alu_sel_q, alu_sel_d;
  logic [7:0]     rsp_data_q, rsp_data_d;
  logic           rsp_carry_q, rsp_carry_d;
  logic [3:0]     rsp_tag_q, rsp_tag_d;
  logic           rsp_err_q, rsp_err_d;

  cmd_t           cmd_in, head;
  logic           fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;

  assign cmd_in = {bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_tag};

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.cmd_valid),
    .din   (cmd_in),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Tag is latched at pop; it is not visible until RESP so the capture point is equivalent.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          rsp_tag_d = head.tag;
          if (is_err_cmd(head)) begin
            rsp_data_d  = 8'h00;
            rsp_carry_d = 1'b0;
            rsp_err_d   = 1'b1;
            state_d     = ST_RESP;
          end else begin
            alu_a_d    = head.a;
            alu_b_d    = head.b;
            alu_sel_d  = head.op;
            wait_cnt_d = WCW'(WAIT_CYCLES - 1);
            state_d    = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: begin
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end else begin
          rsp_data_d  = alu_out;
          rsp_carry_d = (alu_sel_q == OP_ADD) ? alu_carry : 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.rsp_err   = rsp_err_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_sel       = alu_sel_q;
  assign busy          = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench: stimulus pushes model-predicted responses, a negedge monitor checks them.
module tb_alu_cmd_sequencer;

  typedef struct packed {
    logic       err;
    logic       carry;
    logic [3:0] tag;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if bus0();
  alu_cmd_sequencer_if bus3();

  logic [7:0] alu_a0, alu_b0, alu_out0, alu_a3, alu_b3, alu_out3;
  logic [3:0] alu_sel0, alu_sel3;
  logic       alu_carry0, alu_carry3, busy0, busy3;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  logic rand_rdy;
  logic hold_v = 1'b0;
  logic [14:0] hold_val;

  // Peer ALU: carry is the natural overflow/borrow bit, so masking in the DUT is observable.
  function automatic logic [8:0] alu_peer(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] sel);
    logic [15:0] p;
    p = 16'h0;
    case (sel)
      4'd0: return {1'b0, a} + {1'b0, b};
      4'd1: return {1'b0, a} - {1'b0, b};
      4'd2: begin p = a * b; return {|p[15:8], p[7:0]}; end
      4'd3: return {1'b0, (b == 8'h00) ? 8'hFF : a / b};
      4'd4: return {a[7], a[6:0], 1'b0};
      4'd5: return {a[0], 1'b0, a[7:1]};
      4'd6: return {1'b0, a & b};
      4'd7: return {1'b0, a | b};
      default: return 9'h0;
    endcase
  endfunction

  assign {alu_carry0, alu_out0} = alu_peer(alu_a0, alu_b0, alu_sel0);
  assign {alu_carry3, alu_out3} = alu_peer(alu_a3, alu_b3, alu_sel3);

  alu_cmd_sequencer #(.DEPTH(4), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_sel(alu_sel0),
    .alu_out(alu_out0), .alu_carry(alu_carry0), .busy(busy0)
  );

  alu_cmd_sequencer #(.DEPTH(4), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3),
    .alu_out(alu_out3), .alu_carry(alu_carry3), .busy(busy3)
  );

  // Reference response from the opcode rules using plain integer arithmetic.
  function automatic exp_t model(input int op, input int a, input int b, input int tag);
    exp_t e;
    int   r;
    e.tag = tag[3:0];
    if (op > 7 || (op == 3 && b == 0)) begin
      e.err = 1'b1; e.carry = 1'b0; e.data = 8'h00;
      return e;
    end
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      3: r = a / b;
      4: r = a * 2;
      5: r = a / 2;
      6: r = a & b;
      default: r = a | b;
    endcase
    r       = r & 255;
    e.err   = 1'b0;
    e.data  = r[7:0];
    e.carry = (op == 0) && ((a + b) > 255);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input int op, input int a, input int b, input int tag);
    int waits;
    waits = 0;
    bus0.cmd_op    = op[3:0];
    bus0.cmd_a     = a[7:0];
    bus0.cmd_b     = b[7:0];
    bus0.cmd_tag   = tag[3:0];
    bus0.cmd_valid = 1'b1;
    @(negedge clk);
    while (!bus0.cmd_ready && waits < 300) begin
      @(posedge clk); #1;
      if (rand_rdy) bus0.rsp_ready = 1'($urandom_range(0, 1));
      waits++;
      @(negedge clk);
    end
    check("cmd_accept_in_budget", 32'(waits < 300), 32'd1);
    if (waits < 300) sb_q.push_back(model(op, a, b, tag));
    @(posedge clk); #1;
    bus0.cmd_valid = 1'b0;
    if (rand_rdy) bus0.rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic count_edges(output int n);
    n = 0;
    while (!bus0.rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy0) && n < 500) begin
      @(posedge clk); #1;
      if (rand_rdy) bus0.rsp_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check({name, "_drain"}, 32'(n < 500), 32'd1);
  endtask

  task automatic d3_cmd(input int op, input int a, input int b, input int tag, input int lat);
    int   n;
    exp_t e;
    e = model(op, a, b, tag);
    bus3.cmd_op = op[3:0]; bus3.cmd_a = a[7:0]; bus3.cmd_b = b[7:0]; bus3.cmd_tag = tag[3:0];
    bus3.cmd_valid = 1'b1;
    @(negedge clk);
    check("d3_cmd_ready", 32'(bus3.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bus3.cmd_valid = 1'b0;
    n = 0;
    while (!bus3.rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("d3_latency", n, lat);
    check("d3_rsp", {bus3.rsp_err, bus3.rsp_carry, bus3.rsp_tag, bus3.rsp_data}, e);
    $display("dut3 rsp tag=%0d data=%02h carry=%0b err=%0b edges=%0d",
             bus3.rsp_tag, bus3.rsp_data, bus3.rsp_carry, bus3.rsp_err, n);
    @(posedge clk); #1;
  endtask

  // Monitor: compare each accepted response with the queue head; check hold under backpressure.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v)
        check("rsp_stable", {bus0.rsp_valid, bus0.rsp_err, bus0.rsp_carry, bus0.rsp_tag,
                             bus0.rsp_data}, hold_val);
      if (bus0.rsp_valid && bus0.rsp_ready) begin
        $display("rsp tag=%0d data=%02h carry=%0b err=%0b", bus0.rsp_tag, bus0.rsp_data,
                 bus0.rsp_carry, bus0.rsp_err);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got tag %0d data 0x%0h, expected no response",
                   bus0.rsp_tag, bus0.rsp_data);
        end else begin
          check("rsp", {bus0.rsp_err, bus0.rsp_carry, bus0.rsp_tag, bus0.rsp_data}, sb_q[0]);
          void'(sb_q.pop_front());
        end
      end
      hold_v   <= bus0.rsp_valid && !bus0.rsp_ready;
      hold_val <= {bus0.rsp_valid, bus0.rsp_err, bus0.rsp_carry, bus0.rsp_tag, bus0.rsp_data};
    end
  end

  initial begin
    int e;
    rst_n = 1'b0;
    rand_rdy = 1'b0;
    bus0.cmd_valid = 1'b0; bus0.cmd_op = '0; bus0.cmd_a = '0; bus0.cmd_b = '0;
    bus0.cmd_tag = '0; bus0.rsp_ready = 1'b0;
    bus3.cmd_valid = 1'b0; bus3.cmd_op = '0; bus3.cmd_a = '0; bus3.cmd_b = '0;
    bus3.cmd_tag = '0; bus3.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus0.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_alu", {alu_a0, alu_b0, alu_sel0}, 32'd0);
    check("rst_rsp", {bus0.rsp_err, bus0.rsp_carry, bus0.rsp_tag, bus0.rsp_data}, 32'd0);
    check("rst_d3_cmd_ready", 32'(bus3.cmd_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus0.rsp_ready = 1'b1;

    // Single add, two-edge latency.
    send(0, 'hF0, 'h20, 3);
    count_edges(e);
    check("add_latency", e, 2);
    wait_drain("add");

    // Divide-by-zero: answered after one edge, ALU lines keep the previous command.
    send(3, 'h09, 0, 5);
    count_edges(e);
    check("div0_latency", e, 1);
    check("div0_alu_hold", {alu_a0, alu_b0, alu_sel0}, {8'hF0, 8'h20, 4'h0});
    wait_drain("div0");

    // Mixed opcodes.
    send(2, 'h10, 'h11, 1);
    send(1, 3, 5, 2);
    send(4, 'h81, 'h00, 3);
    send(5, 'h81, 'h00, 6);
    send(4'hA, 'h12, 'h34, 4);
    wait_drain("mixed");

    // Backpressure: 1 in flight + 4 queued, then full.
    bus0.rsp_ready = 1'b0;
    for (int t = 0; t < 5; t++) send(6, $urandom_range(0, 255), $urandom_range(0, 255), t);
    @(negedge clk);
    check("bp_cmd_ready_full", 32'(bus0.cmd_ready), 32'd0);
    check("bp_count", 32'(u_dut.fifo_count), 32'd4);
    @(posedge clk); #1;
    bus0.cmd_op = 4'd7; bus0.cmd_tag = 4'hF; bus0.cmd_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus0.cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_head_tag", {bus0.rsp_valid, bus0.rsp_tag}, {1'b1, 4'd0});
    check("bp_count_after_ignored", 32'(u_dut.fifo_count), 32'd4);
    @(posedge clk); #1;
    bus0.rsp_ready = 1'b1;
    wait_drain("bp");

    // Push and pop on the same edge with two entries queued.
    bus0.rsp_ready = 1'b0;
    send(0, 1, 2, 8);
    send(0, 3, 4, 9);
    send(0, 5, 6, 10);
    check("pp_count_before", 32'(u_dut.fifo_count), 32'd2);
    bus0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("pp_count_resp_edge", 32'(u_dut.fifo_count), 32'd2);
    send(0, 'hFF, 'hFF, 11);
    check("pp_count_same_edge", 32'(u_dut.fifo_count), 32'd2);
    wait_drain("pp");

    // Reset while DRIVE is active and two commands are queued.
    bus0.rsp_ready = 1'b0;
    send(7, 1, 2, 1);
    send(7, 3, 4, 2);
    send(7, 5, 6, 3);
    send(7, 7, 8, 4);
    bus0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", 32'(busy0), 32'd1);
    check("mid_count", 32'(u_dut.fifo_count), 32'd2);
    check("mid_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    rst_n = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    check("rstmid_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    check("rstmid_busy", 32'(busy0), 32'd0);
    check("rstmid_cmd_ready", 32'(bus0.cmd_ready), 32'd1);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_quiet", {bus0.rsp_valid, busy0}, 32'd0);

    // Randomized traffic with random sink backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int op, a, b;
      op = $urandom_range(0, 9);
      a  = $urandom_range(0, 255);
      b  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 255);
      send(op, a, b, i % 16);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        bus0.rsp_ready = 1'($urandom_range(0, 1));
      end
    end
    rand_rdy = 1'b0;
    bus0.rsp_ready = 1'b1;
    wait_drain("rand");

    // Longer settle time on the second instance.
    d3_cmd(0, 'h7F, 'h01, 9, 4);
    d3_cmd(9, 'h11, 'h22, 12, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded, expected completion");
    $fatal(1, "timeout");
  end

endmodule
